// File: rtl/k423_wb_load_queue.sv
// k423_wb_load_queue: in-order writeback queue that merges ALU results with
// load responses. It extracts and extends load lanes, and after a flush it
// drops load responses that are still owed.
// Optional feature macro: K423_WB_MISALIGN_CHK_EN. When it is defined,
// misaligned loads complete at enqueue and are flagged on wb_misalign_o.
module k423_wb_load_queue #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ex_vld_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              ex_rd_vld_i,
  input  logic [4:0]        ex_rd_idx_i,
  input  logic [XLEN-1:0]   ex_rd_i,
  output logic              ex_rdy_o,
  input  logic              ex_load_i,
  input  logic [1:0]        ex_load_size_i,
  input  logic              ex_load_unsigned_i,
  input  logic [ADDR_W-1:0] ex_load_addr_i,
  input  logic              mem_rsp_vld_i,
  input  logic [XLEN-1:0]   mem_rsp_rdata_i,
  input  logic              flush_i,
  input  logic              wb_rdy_i,
  output logic              wb_vld_o,
  output logic [ADDR_W-1:0] wb_pc_o,
  output logic              wb_rd_vld_o,
  output logic [4:0]        wb_rd_idx_o,
  output logic [XLEN-1:0]   wb_rd_o,
  output logic              wb_misalign_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DROP_W = PTR_W + 2;
  localparam int OFF_W  = $clog2(XLEN / 8);

`ifdef K423_WB_MISALIGN_CHK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif

  // Queue storage
  logic [ADDR_W-1:0] q_pc     [DEPTH];
  logic [4:0]        q_rd_idx [DEPTH];
  logic [XLEN-1:0]   q_rd     [DEPTH];
  logic [1:0]        q_size   [DEPTH];
  logic [OFF_W-1:0]  q_off    [DEPTH];
  logic [DEPTH-1:0]  q_rd_vld;
  logic [DEPTH-1:0]  q_mis;
  logic [DEPTH-1:0]  q_uns;
  logic [DEPTH-1:0]  q_pend;

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [DROP_W-1:0] drop_cnt, pend_cnt, drop_flush;

  logic              push, pop;
  logic              in_mis, in_pend, in_rd_vld;
  logic [XLEN-1:0]   in_rd;
  logic              rsp_found, rsp_hit, rsp_drop;
  logic [PTR_W-1:0]  rsp_idx;
  logic [XLEN-1:0]   rsp_data;
  logic              head_ok, head_rd_vld, head_mis, head_hit;
  logic [ADDR_W-1:0] head_pc;
  logic [4:0]        head_rd_idx;
  logic [XLEN-1:0]   head_rd;
  logic              unused_addr;

  // A load is misaligned when its offset does not fit the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic res;
    case (size)
      2'b00:   res = 1'b0;
      2'b01:   res = off[0];
      2'b10:   res = (off[1:0] != 2'b00);
      default: res = (XLEN == 32) ? 1'b1 : (off != '0);
    endcase
    return res;
  endfunction

  // Lane select plus sign/zero extension. Lanes that do not match give zero.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] data, input logic [1:0] size,
                                             input logic uns, input logic [OFF_W-1:0] off);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh  = data >> {off, 3'b000};
    res = '0;
    if (!misaligned(size, off)) begin
      case (size)
        2'b00:   res = uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
        2'b01:   res = uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
        2'b10:   res = uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
        default: res = sh;
      endcase
    end
    return res;
  endfunction

  assign unused_addr = ^ex_load_addr_i[ADDR_W-1:OFF_W];
  assign ex_rdy_o    = (count != CNT_W'(DEPTH));
  assign push        = ex_vld_i && ex_rdy_o && !flush_i;

  // Incoming entry fields. A checked misaligned load carries no data and no rd write.
  always_comb begin
    in_mis    = MIS_CHK && ex_load_i && misaligned(ex_load_size_i, ex_load_addr_i[OFF_W-1:0]);
    in_pend   = ex_load_i && !in_mis;
    in_rd_vld = ex_rd_vld_i && !in_mis;
    in_rd     = ex_load_i ? '0 : ex_rd_i;
  end

  // Oldest pending load, searched in age order starting from the head.
  always_comb begin
    rsp_found = 1'b0;
    rsp_idx   = rd_ptr;
    pend_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt = pend_cnt + DROP_W'(q_pend[i]);
      if (!rsp_found && q_pend[rd_ptr + PTR_W'(i)]) begin
        rsp_found = 1'b1;
        rsp_idx   = rd_ptr + PTR_W'(i);
      end
    end
  end

  // Response routing: owed flushed responses are dropped first.
  always_comb begin
    rsp_drop   = mem_rsp_vld_i && !flush_i && (drop_cnt != '0);
    rsp_hit    = mem_rsp_vld_i && !flush_i && (drop_cnt == '0) && rsp_found;
    rsp_data   = extend(mem_rsp_rdata_i, q_size[rsp_idx], q_uns[rsp_idx], q_off[rsp_idx]);
    drop_flush = drop_cnt + pend_cnt
                 - DROP_W'(mem_rsp_vld_i && ((drop_cnt != '0) || (pend_cnt != '0)));
  end

  // Head view with bypass of the incoming entry and of a response to the head.
  always_comb begin
    head_hit    = rsp_hit && (rsp_idx == rd_ptr);
    head_ok     = 1'b0;
    head_pc     = q_pc[rd_ptr];
    head_rd_vld = q_rd_vld[rd_ptr];
    head_rd_idx = q_rd_idx[rd_ptr];
    head_rd     = head_hit ? rsp_data : q_rd[rd_ptr];
    head_mis    = q_mis[rd_ptr];
    if (count == '0) begin
      head_ok     = push && !in_pend;
      head_pc     = ex_pc_i;
      head_rd_vld = in_rd_vld;
      head_rd_idx = ex_rd_idx_i;
      head_rd     = in_rd;
      head_mis    = in_mis;
    end else begin
      head_ok     = !q_pend[rd_ptr] || head_hit;
    end
    pop = head_ok && (!wb_vld_o || wb_rdy_i) && !flush_i;
  end

  // Payload storage; only valid slots are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pc[wr_ptr]     <= ex_pc_i;
      q_rd_idx[wr_ptr] <= ex_rd_idx_i;
      q_rd[wr_ptr]     <= in_rd;
      q_size[wr_ptr]   <= ex_load_size_i;
      q_off[wr_ptr]    <= ex_load_addr_i[OFF_W-1:0];
      q_rd_vld[wr_ptr] <= in_rd_vld;
      q_mis[wr_ptr]    <= in_mis;
      q_uns[wr_ptr]    <= ex_load_unsigned_i;
    end
    if (rsp_hit) begin
      q_rd[rsp_idx] <= rsp_data;
    end
  end

  // Pointers, pending flags, drop counter and the writeback output register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      q_pend        <= '0;
      drop_cnt      <= '0;
      wb_vld_o      <= 1'b0;
      wb_pc_o       <= '0;
      wb_rd_vld_o   <= 1'b0;
      wb_rd_idx_o   <= '0;
      wb_rd_o       <= '0;
      wb_misalign_o <= 1'b0;
    end else if (flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      q_pend   <= '0;
      drop_cnt <= drop_flush;
      wb_vld_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + 1'b1;
        q_pend[wr_ptr] <= in_pend;
      end
      if (rsp_hit) begin
        q_pend[rsp_idx] <= 1'b0;
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        wb_vld_o      <= 1'b1;
        wb_pc_o       <= head_pc;
        wb_rd_vld_o   <= head_rd_vld;
        wb_rd_idx_o   <= head_rd_idx;
        wb_rd_o       <= head_rd;
        wb_misalign_o <= head_mis;
      end else if (wb_rdy_i) begin
        wb_vld_o <= 1'b0;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_k423_wb_load_queue.sv
// tb_k423_wb_load_queue: directed self-checking bench for k423_wb_load_queue
// (XLEN=32, DEPTH=4). Honours K423_WB_MISALIGN_CHK_EN if defined.
module tb_k423_wb_load_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_vld, ex_rd_vld, ex_load, ex_uns, ex_rdy;
  logic [31:0] ex_pc, ex_rd, ex_addr;
  logic [4:0]  ex_idx;
  logic [1:0]  ex_size;
  logic        rsp_vld;
  logic [31:0] rsp_data;
  logic        flush, wb_rdy;
  logic        wb_vld, wb_rd_vld, wb_mis;
  logic [31:0] wb_pc, wb_rd;
  logic [4:0]  wb_idx;

  int tests_run = 0;
  int failures  = 0;

  k423_wb_load_queue #(.XLEN(32), .DEPTH(4), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ex_vld_i(ex_vld), .ex_pc_i(ex_pc), .ex_rd_vld_i(ex_rd_vld), .ex_rd_idx_i(ex_idx),
    .ex_rd_i(ex_rd), .ex_rdy_o(ex_rdy),
    .ex_load_i(ex_load), .ex_load_size_i(ex_size), .ex_load_unsigned_i(ex_uns),
    .ex_load_addr_i(ex_addr),
    .mem_rsp_vld_i(rsp_vld), .mem_rsp_rdata_i(rsp_data),
    .flush_i(flush), .wb_rdy_i(wb_rdy),
    .wb_vld_o(wb_vld), .wb_pc_o(wb_pc), .wb_rd_vld_o(wb_rd_vld), .wb_rd_idx_o(wb_idx),
    .wb_rd_o(wb_rd), .wb_misalign_o(wb_mis)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_vld = 1'b0; ex_load = 1'b0; ex_rd_vld = 1'b0;
  endtask

  task automatic drive_alu(input logic [31:0] pc, input logic [4:0] idx, input logic [31:0] rd);
    ex_vld = 1'b1; ex_load = 1'b0; ex_pc = pc; ex_idx = idx; ex_rd = rd; ex_rd_vld = 1'b1;
    ex_size = 2'b10; ex_uns = 1'b0; ex_addr = '0;
  endtask

  task automatic drive_load(input logic [31:0] pc, input logic [4:0] idx, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr);
    ex_vld = 1'b1; ex_load = 1'b1; ex_pc = pc; ex_idx = idx; ex_rd = '0; ex_rd_vld = 1'b1;
    ex_size = size; ex_uns = uns; ex_addr = addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_vld: got %0b want 0", wb_vld); end
    tests_run++; if (wb_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_wb_pc: got %h want 0", wb_pc); end
    tests_run++; if (wb_rd_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_rd_vld: got %0b want 0", wb_rd_vld); end
    tests_run++; if (wb_idx !== 5'd0) begin failures++; $display("[TB] FAIL reset_wb_idx: got %0d want 0", wb_idx); end
    tests_run++; if (wb_rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_wb_rd: got %h want 0", wb_rd); end
    tests_run++; if (wb_mis !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_mis: got %0b want 0", wb_mis); end
    tests_run++; if (ex_rdy !== 1'b1) begin failures++; $display("[TB] FAIL reset_ex_rdy: got %0b want 1", ex_rdy); end
  endtask

  task automatic test_nonload();
    drive_alu(32'h100, 5'd5, 32'h1234);
    tick();
    idle_ex();
    tests_run++; if (wb_vld !== 1'b1) begin failures++; $display("[TB] FAIL nonload_vld: got %0b want 1", wb_vld); end
    tests_run++; if (wb_rd !== 32'h1234) begin failures++; $display("[TB] FAIL nonload_rd: got %h want 00001234", wb_rd); end
    tests_run++; if (wb_pc !== 32'h100) begin failures++; $display("[TB] FAIL nonload_pc: got %h want 00000100", wb_pc); end
    tests_run++; if (wb_idx !== 5'd5 || wb_rd_vld !== 1'b1) begin failures++; $display("[TB] FAIL nonload_idx: got %0d/%0b want 5/1", wb_idx, wb_rd_vld); end
    tick();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL nonload_drain: got %0b want 0", wb_vld); end
  endtask

  task automatic test_load_extend();
    // signed byte at offset 3
    drive_load(32'h110, 5'd7, 2'b00, 1'b0, 32'h1003);
    tick();
    idle_ex();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL ld_pending: got %0b want 0", wb_vld); end
    rsp_vld = 1'b1; rsp_data = 32'h80FF_FF00;
    tick();
    rsp_vld = 1'b0;
    tests_run++; if (wb_vld !== 1'b1 || wb_rd !== 32'hFFFF_FF80) begin failures++; $display("[TB] FAIL ld_byte_signed: got %0b/%h want 1/ffffff80", wb_vld, wb_rd); end
    tests_run++; if (wb_idx !== 5'd7 || wb_pc !== 32'h110) begin failures++; $display("[TB] FAIL ld_byte_tag: got %0d/%h want 7/00000110", wb_idx, wb_pc); end
    tick();
    // unsigned byte at offset 3
    drive_load(32'h114, 5'd8, 2'b00, 1'b1, 32'h1003);
    tick();
    idle_ex();
    rsp_vld = 1'b1; rsp_data = 32'h80FF_FF00;
    tick();
    rsp_vld = 1'b0;
    tests_run++; if (wb_vld !== 1'b1 || wb_rd !== 32'h0000_0080) begin failures++; $display("[TB] FAIL ld_byte_unsigned: got %0b/%h want 1/00000080", wb_vld, wb_rd); end
    tick();
    // signed half at offset 2
    drive_load(32'h118, 5'd9, 2'b01, 1'b0, 32'h2002);
    tick();
    idle_ex();
    rsp_vld = 1'b1; rsp_data = 32'h8001_1234;
    tick();
    rsp_vld = 1'b0;
    tests_run++; if (wb_vld !== 1'b1 || wb_rd !== 32'hFFFF_8001) begin failures++; $display("[TB] FAIL ld_half_signed: got %0b/%h want 1/ffff8001", wb_vld, wb_rd); end
    tick();
    // signed word on XLEN=32 passes through
    drive_load(32'h11C, 5'd10, 2'b10, 1'b0, 32'h3000);
    tick();
    idle_ex();
    rsp_vld = 1'b1; rsp_data = 32'h8765_4321;
    tick();
    rsp_vld = 1'b0;
    tests_run++; if (wb_vld !== 1'b1 || wb_rd !== 32'h8765_4321) begin failures++; $display("[TB] FAIL ld_word: got %0b/%h want 1/87654321", wb_vld, wb_rd); end
    tick();
  endtask

  task automatic test_order();
    drive_load(32'h200, 5'd1, 2'b10, 1'b0, 32'h0);
    tick();
    drive_alu(32'h204, 5'd2, 32'hBBBB);
    tick();
    idle_ex();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL order_wait%0d: got %0b want 0", i, wb_vld); end
    end
    rsp_vld = 1'b1; rsp_data = 32'h1122_3344;
    tick();
    rsp_vld = 1'b0;
    tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h200 || wb_rd !== 32'h1122_3344) begin failures++; $display("[TB] FAIL order_first: got %0b/%h/%h want 1/00000200/11223344", wb_vld, wb_pc, wb_rd); end
    tick();
    tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h204 || wb_rd !== 32'hBBBB) begin failures++; $display("[TB] FAIL order_second: got %0b/%h/%h want 1/00000204/0000bbbb", wb_vld, wb_pc, wb_rd); end
    tick();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL order_drain: got %0b want 0", wb_vld); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive_load(32'h300 + 32'(4 * i), 5'(i + 1), 2'b10, 1'b0, 32'h0);
      tick();
    end
    tests_run++; if (ex_rdy !== 1'b0) begin failures++; $display("[TB] FAIL full_rdy_low: got %0b want 0", ex_rdy); end
    // an ALU op offered while full, in the same cycle the head completes
    drive_alu(32'h400, 5'd20, 32'h4444);
    rsp_vld = 1'b1; rsp_data = 32'hA0;
    tick();
    idle_ex();
    tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h300 || wb_rd !== 32'hA0) begin failures++; $display("[TB] FAIL full_head: got %0b/%h/%h want 1/00000300/000000a0", wb_vld, wb_pc, wb_rd); end
    tests_run++; if (ex_rdy !== 1'b1) begin failures++; $display("[TB] FAIL full_rdy_rise: got %0b want 1", ex_rdy); end
    for (int i = 1; i < 4; i++) begin
      rsp_data = 32'hA0 + 32'(i);
      tick();
      tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h300 + 32'(4 * i) || wb_rd !== 32'hA0 + 32'(i)) begin failures++; $display("[TB] FAIL full_stream%0d: got %0b/%h/%h want 1/%h/%h", i, wb_vld, wb_pc, wb_rd, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i)); end
    end
    rsp_vld = 1'b0;
    tick();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL full_no_extra: got %0b/%h want 0", wb_vld, wb_pc); end
  endtask

  task automatic test_stall();
    wb_rdy = 1'b0;
    drive_alu(32'h800, 5'd3, 32'h8888);
    tick();
    drive_alu(32'h804, 5'd4, 32'h9999);
    tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h800) begin failures++; $display("[TB] FAIL stall_load: got %0b/%h want 1/00000800", wb_vld, wb_pc); end
    tick();
    idle_ex();
    for (int i = 0; i < 2; i++) begin
      tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h800 || wb_rd !== 32'h8888 || wb_idx !== 5'd3) begin failures++; $display("[TB] FAIL stall_hold%0d: got %0b/%h/%h want 1/00000800/00008888", i, wb_vld, wb_pc, wb_rd); end
      tick();
    end
    wb_rdy = 1'b1;
    tick();
    tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h804 || wb_rd !== 32'h9999) begin failures++; $display("[TB] FAIL stall_next: got %0b/%h/%h want 1/00000804/00009999", wb_vld, wb_pc, wb_rd); end
    tick();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL stall_drain: got %0b want 0", wb_vld); end
  endtask

  task automatic test_flush();
    drive_load(32'h500, 5'd1, 2'b10, 1'b0, 32'h0);
    tick();
    drive_load(32'h504, 5'd2, 2'b10, 1'b0, 32'h0);
    tick();
    drive_alu(32'h5FF, 5'd9, 32'h5555);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++; if (wb_vld !== 1'b0 || ex_rdy !== 1'b1) begin failures++; $display("[TB] FAIL flush_clear: got %0b/%0b want 0/1", wb_vld, ex_rdy); end
    drive_load(32'h600, 5'd6, 2'b10, 1'b0, 32'h0);
    tick();
    idle_ex();
    rsp_vld = 1'b1; rsp_data = 32'hD1;
    tick();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL flush_drop1: got %0b/%h want 0", wb_vld, wb_rd); end
    rsp_data = 32'hD2;
    tick();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL flush_drop2: got %0b/%h want 0", wb_vld, wb_rd); end
    rsp_data = 32'hC3;
    tick();
    rsp_vld = 1'b0;
    tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h600 || wb_rd !== 32'hC3) begin failures++; $display("[TB] FAIL flush_c: got %0b/%h/%h want 1/00000600/000000c3", wb_vld, wb_pc, wb_rd); end
    tick();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL flush_drain: got %0b/%h want 0", wb_vld, wb_pc); end
  endtask

  task automatic test_flush_rsp();
    drive_load(32'h700, 5'd1, 2'b10, 1'b0, 32'h0);
    tick();
    idle_ex();
    flush = 1'b1; rsp_vld = 1'b1; rsp_data = 32'hEE;
    tick();
    flush = 1'b0; rsp_vld = 1'b0;
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL flushrsp_clear: got %0b want 0", wb_vld); end
    drive_load(32'h704, 5'd2, 2'b10, 1'b0, 32'h0);
    tick();
    idle_ex();
    rsp_vld = 1'b1; rsp_data = 32'h77;
    tick();
    rsp_vld = 1'b0;
    tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h704 || wb_rd !== 32'h77) begin failures++; $display("[TB] FAIL flushrsp_d: got %0b/%h/%h want 1/00000704/00000077", wb_vld, wb_pc, wb_rd); end
    tick();
  endtask

  task automatic test_misalign();
    drive_load(32'h900, 5'd11, 2'b01, 1'b0, 32'h1);
    tick();
    idle_ex();
`ifdef K423_WB_MISALIGN_CHK_EN
    tests_run++; if (wb_vld !== 1'b1 || wb_mis !== 1'b1) begin failures++; $display("[TB] FAIL mis_flag: got %0b/%0b want 1/1", wb_vld, wb_mis); end
    tests_run++; if (wb_rd_vld !== 1'b0 || wb_rd !== 32'h0) begin failures++; $display("[TB] FAIL mis_data: got %0b/%h want 0/0", wb_rd_vld, wb_rd); end
    drive_load(32'h904, 5'd12, 2'b10, 1'b0, 32'h0);
    tick();
    idle_ex();
    rsp_vld = 1'b1; rsp_data = 32'h55;
    tick();
    rsp_vld = 1'b0;
    tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h904 || wb_rd !== 32'h55 || wb_mis !== 1'b0) begin failures++; $display("[TB] FAIL mis_next_load: got %0b/%h/%h/%0b want 1/00000904/00000055/0", wb_vld, wb_pc, wb_rd, wb_mis); end
`else
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL mis_wait0: got %0b want 0", wb_vld); end
    tick();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL mis_wait1: got %0b want 0", wb_vld); end
    rsp_vld = 1'b1; rsp_data = 32'hFFFF_FFFF;
    tick();
    rsp_vld = 1'b0;
    tests_run++; if (wb_vld !== 1'b1 || wb_pc !== 32'h900 || wb_rd !== 32'h0 || wb_mis !== 1'b0) begin failures++; $display("[TB] FAIL mis_zero: got %0b/%h/%h/%0b want 1/00000900/0/0", wb_vld, wb_pc, wb_rd, wb_mis); end
`endif
    tick();
    tests_run++; if (wb_vld !== 1'b0) begin failures++; $display("[TB] FAIL mis_drain: got %0b want 0", wb_vld); end
  endtask

  // Test sequence
  initial begin
    rst_n = 1'b0;
    idle_ex();
    ex_pc = '0; ex_idx = '0; ex_rd = '0; ex_size = '0; ex_uns = 1'b0; ex_addr = '0;
    rsp_vld = 1'b0; rsp_data = '0; flush = 1'b0; wb_rdy = 1'b1;
    test_reset();
    test_nonload();
    test_load_extend();
    test_order();
    test_full();
    test_stall();
    test_flush();
    test_flush_rsp();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
